watchdog_tx_supervisor: RTL and testbench
=========================================

Name: watchdog_tx_supervisor

Overview:
- Sequences the AM transmitter around the existing watchdog_timer.
- Drives the watchdog's enable and force_reset inputs.
- Ramps the RF amplitude scale up on start and down on stop or fault.
- After a watchdog trip: performs bounded automatic restarts, then latches a lockout until software clears it.
- Sits between the control register block and the DAC gain stage.

Parameters:
- RAMP_STEP, 16, amplitude increment/decrement per clock during ramps (1..255).
- HOLDOFF_CYCLES, 1000, clock cycles spent in HOLDOFF before a restart attempt (>=1).
- MAX_RETRIES, 3, number of faults that forces LOCKOUT (1..15).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_request  in  1  level; software requests transmitter on.
- clear_fault  in  1  single-cycle pulse; exits LOCKOUT.
- wd_triggered  in  1  watchdog trip output.
- wd_warning  in  1  watchdog early-warning output.
- wd_enable  out  1  to watchdog enable.
- wd_force_reset  out  1  to watchdog force_reset.
- rf_enable  out  1  RF output stage enable.
- amp_scale  out  8  DAC gain scale, 0..255.
- state  out  3  IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3, HOLDOFF=4, LOCKOUT=5.
- retry_count  out  4  faults since last clean stop.
- fault_lockout  out  1  high in LOCKOUT.
- warn_seen  out  1  sticky: wd_warning was sampled high in RUN.

Behaviour:
- All outputs registered.
- Reset values: state=IDLE, amp_scale=0, rf_enable=0, wd_enable=0, wd_force_reset=1, retry_count=0, fault_lockout=0, warn_seen=0.
- rst in any state, including mid-ramp: next edge forces reset values. No ramp-down is performed.
- Decoded outputs:
  - wd_enable=1 only in RAMP_UP and RUN.
  - wd_force_reset=1 in every other state, so the watchdog counter is clean on each start.
  - rf_enable=1 in RAMP_UP, RUN and RAMP_DOWN.
- IDLE: amp_scale=0. tx_request=1 -> RAMP_UP next cycle.
- RAMP_UP:
  - Each cycle amp_scale <= min(amp_scale+RAMP_STEP, 255).
  - On the edge where the result is 255 -> RUN.
  - With RAMP_STEP=16: values 0,16,...,240 over 16 RAMP_UP cycles, then RUN with 255.
- RUN: amp_scale holds 255. wd_warning=1 sets warn_seen; warn_seen clears only on rst or on entry to RAMP_UP.
- Exits from RAMP_UP/RUN, priority order:
  - wd_triggered=1 -> RAMP_DOWN marked fault; retry_count increments, saturating at MAX_RETRIES.
  - Otherwise tx_request=0 -> RAMP_DOWN marked clean.
  - Fault wins when both occur in the same cycle.
- RAMP_DOWN:
  - Each cycle amp_scale <= max(amp_scale-RAMP_STEP, 0), starting from the current value (a ramp may be aborted partway).
  - tx_request and wd_triggered are ignored.
  - On the edge where the result is 0:
    - clean -> IDLE, with retry_count cleared to 0;
    - fault with retry_count==MAX_RETRIES -> LOCKOUT;
    - otherwise fault -> HOLDOFF.
- HOLDOFF:
  - Lasts exactly HOLDOFF_CYCLES cycles; counter loaded on entry.
  - At expiry: tx_request=1 -> RAMP_UP (retry_count kept); tx_request=0 -> IDLE (retry_count cleared).
- LOCKOUT:
  - Outputs held off; fault_lockout=1.
  - clear_fault=1 -> IDLE, with retry_count=0.
  - tx_request is ignored.
- clear_fault outside LOCKOUT: ignored.
- wd_triggered outside RAMP_UP/RUN: ignored.
- state is never outside 0..5; illegal encodings recover to IDLE.

Test Plan (RAMP_STEP=16, HOLDOFF_CYCLES=8, MAX_RETRIES=3):
1. Normal start:
   - Stimulus: rst 2 cycles, then tx_request=1.
   - Response: wd_force_reset drops and wd_enable rises on entry to RAMP_UP; amp_scale 0,16,...,240 over 16 cycles, then 255 with state=2.
2. Clean stop:
   - Stimulus: drop tx_request in RUN.
   - Response: amp_scale 255,239,...,15, then 0 after 16 cycles; state=IDLE, rf_enable=0, retry_count=0.
3. Fault recovery:
   - Stimulus: pulse wd_triggered in RUN.
   - Response: retry_count=1, RAMP_DOWN 16 cycles, HOLDOFF 8 cycles, RAMP_UP with wd_force_reset low.
4. Lockout:
   - Stimulus: three faults in sequence.
   - Response: after the third ramp-down, state=5 and fault_lockout=1; tx_request is ignored.
   - Stimulus: clear_fault pulse.
   - Response: IDLE, retry_count=0.
5. Simultaneous events:
   - Stimulus: wd_triggered and tx_request fall in the same RUN cycle.
   - Response: fault path taken (retry_count increments); afterwards HOLDOFF -> IDLE.
   - Stimulus: tx_request drops at amp_scale=96 in RAMP_UP.
   - Response: ramp-down from 96 reaches 0 in 6 cycles.
6. Reset mid-ramp:
   - Stimulus: rst=1 during RAMP_DOWN with amp_scale=128.
   - Response: next cycle amp_scale=0, state=0, wd_force_reset=1.
   - Stimulus: wd_warning in RUN.
   - Response: warn_seen=1 until the next RAMP_UP.

Source files
------------

// File: rtl/watchdog_tx_supervisor.sv
// Transmitter sequencer around the watchdog timer: amplitude ramps on start/stop,
// bounded automatic restarts after a watchdog trip, and a software-cleared lockout.
module watchdog_tx_supervisor #(
    parameter int unsigned RAMP_STEP      = 16,
    parameter int unsigned HOLDOFF_CYCLES = 1000,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_request,
    input  logic       clear_fault,
    input  logic       wd_triggered,
    input  logic       wd_warning,
    output logic       wd_enable,
    output logic       wd_force_reset,
    output logic       rf_enable,
    output logic [7:0] amp_scale,
    output logic [2:0] state,
    output logic [3:0] retry_count,
    output logic       fault_lockout,
    output logic       warn_seen
);

    localparam int unsigned HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [7:0]  STEP   = 8'(RAMP_STEP);
    localparam logic [3:0]  MAX_R  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RAMP_UP   = 3'd1,
        S_RUN       = 3'd2,
        S_RAMP_DOWN = 3'd3,
        S_HOLDOFF   = 3'd4,
        S_LOCKOUT   = 3'd5
    } state_t;

    state_t              state_q;
    state_t              state_n;
    logic [7:0]          amp_n;
    logic [3:0]          retry_n;
    logic                fault_q;
    logic                fault_n;
    logic [HOLD_W-1:0]   hold_q;
    logic [HOLD_W-1:0]   hold_n;
    logic                warn_n;
    logic                wd_enable_n;
    logic                rf_enable_n;
    logic                lockout_n;
    logic [8:0]          amp_sum;
    logic [7:0]          amp_up;
    logic [7:0]          amp_dn;
    logic [3:0]          retry_inc;

    // Saturating ramp arithmetic and retry increment
    always_comb begin
        amp_sum   = {1'b0, amp_scale} + {1'b0, STEP};
        amp_up    = amp_sum[8] ? 8'hFF : amp_sum[7:0];
        amp_dn    = (amp_scale > STEP) ? (amp_scale - STEP) : 8'd0;
        retry_inc = (retry_count < MAX_R) ? (retry_count + 4'd1) : retry_count;
    end

    // Next-state and next-output logic
    always_comb begin
        state_n = state_q;
        amp_n   = amp_scale;
        retry_n = retry_count;
        fault_n = fault_q;
        hold_n  = hold_q;
        warn_n  = warn_seen;

        case (state_q)
            S_IDLE: begin
                amp_n = 8'd0;
                if (tx_request) begin
                    state_n = S_RAMP_UP;
                end
            end
            S_RAMP_UP, S_RUN: begin
                if (state_q == S_RUN) begin
                    amp_n = 8'hFF;
                    if (wd_warning) begin
                        warn_n = 1'b1;
                    end
                end
                if (wd_triggered) begin
                    state_n = S_RAMP_DOWN;
                    fault_n = 1'b1;
                    retry_n = retry_inc;
                end else if (!tx_request) begin
                    state_n = S_RAMP_DOWN;
                    fault_n = 1'b0;
                end else if (state_q == S_RAMP_UP) begin
                    amp_n = amp_up;
                    if (amp_up == 8'hFF) begin
                        state_n = S_RUN;
                    end
                end
            end
            S_RAMP_DOWN: begin
                amp_n = amp_dn;
                if (amp_dn == 8'd0) begin
                    if (!fault_q) begin
                        state_n = S_IDLE;
                        retry_n = 4'd0;
                    end else if (retry_count == MAX_R) begin
                        state_n = S_LOCKOUT;
                    end else begin
                        state_n = S_HOLDOFF;
                        hold_n  = HOLD_W'(HOLDOFF_CYCLES - 1);
                    end
                end
            end
            S_HOLDOFF: begin
                amp_n = 8'd0;
                if (hold_q == '0) begin
                    if (tx_request) begin
                        state_n = S_RAMP_UP;
                    end else begin
                        state_n = S_IDLE;
                        retry_n = 4'd0;
                    end
                end else begin
                    hold_n = hold_q - HOLD_W'(1);
                end
            end
            S_LOCKOUT: begin
                amp_n = 8'd0;
                if (clear_fault) begin
                    state_n = S_IDLE;
                    retry_n = 4'd0;
                end
            end
            default: begin
                state_n = S_IDLE;
                amp_n   = 8'd0;
                retry_n = 4'd0;
                fault_n = 1'b0;
            end
        endcase

        // Every start sees a fresh warning flag
        if ((state_n == S_RAMP_UP) && (state_q != S_RAMP_UP)) begin
            warn_n = 1'b0;
        end

        wd_enable_n = (state_n == S_RAMP_UP) || (state_n == S_RUN);
        rf_enable_n = wd_enable_n || (state_n == S_RAMP_DOWN);
        lockout_n   = (state_n == S_LOCKOUT);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            amp_scale      <= 8'd0;
            retry_count    <= 4'd0;
            fault_q        <= 1'b0;
            hold_q         <= '0;
            warn_seen      <= 1'b0;
            wd_enable      <= 1'b0;
            wd_force_reset <= 1'b1;
            rf_enable      <= 1'b0;
            fault_lockout  <= 1'b0;
        end else begin
            state_q        <= state_n;
            amp_scale      <= amp_n;
            retry_count    <= retry_n;
            fault_q        <= fault_n;
            hold_q         <= hold_n;
            warn_seen      <= warn_n;
            wd_enable      <= wd_enable_n;
            wd_force_reset <= !wd_enable_n;
            rf_enable      <= rf_enable_n;
            fault_lockout  <= lockout_n;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_watchdog_tx_supervisor.sv
// Directed scoreboard bench for watchdog_tx_supervisor: stimulus queues the expected
// post-edge snapshot, a negedge monitor pops and compares it.
module tb_watchdog_tx_supervisor;

    logic       clk;
    logic       rst;
    logic       tx_request;
    logic       clear_fault;
    logic       wd_triggered;
    logic       wd_warning;
    logic       wd_enable;
    logic       wd_force_reset;
    logic       rf_enable;
    logic [7:0] amp_scale;
    logic [2:0] state;
    logic [3:0] retry_count;
    logic       fault_lockout;
    logic       warn_seen;

    watchdog_tx_supervisor #(
        .RAMP_STEP(16),
        .HOLDOFF_CYCLES(8),
        .MAX_RETRIES(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tx_request(tx_request),
        .clear_fault(clear_fault),
        .wd_triggered(wd_triggered),
        .wd_warning(wd_warning),
        .wd_enable(wd_enable),
        .wd_force_reset(wd_force_reset),
        .rf_enable(rf_enable),
        .amp_scale(amp_scale),
        .state(state),
        .retry_count(retry_count),
        .fault_lockout(fault_lockout),
        .warn_seen(warn_seen)
    );

    typedef struct packed {
        logic [7:0] phase;
        logic [2:0] st;
        logic [7:0] amp;
        logic [3:0] retry;
        logic       wen;
        logic       frc;
        logic       rf;
        logic       lock;
        logic       warn;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   phase  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected snapshot; decoded outputs follow the state table
    function automatic exp_t mk(input logic [2:0] st, input int amp, input int r, input logic w);
        exp_t e;
        e.phase = 8'(phase);
        e.st    = st;
        e.amp   = 8'(amp);
        e.retry = 4'(r);
        e.wen   = (st == 3'd1) || (st == 3'd2);
        e.frc   = !((st == 3'd1) || (st == 3'd2));
        e.rf    = (st == 3'd1) || (st == 3'd2) || (st == 3'd3);
        e.lock  = (st == 3'd5);
        e.warn  = w;
        return e;
    endfunction

    task automatic tick(input logic [2:0] st, input int amp, input int r, input logic w);
        @(posedge clk);
        #1;
        sbq.push_back(mk(st, amp, r, w));
    endtask

    task automatic ramp_up_full(input int r);
        for (int i = 1; i <= 15; i++) tick(3'd1, 16 * i, r, 1'b0);
        tick(3'd2, 255, r, 1'b0);
    endtask

    task automatic ramp_down(input int start, input int r, input logic w,
                             input logic [2:0] fin, input int rfin);
        int a;
        a = start;
        while (a > 16) begin
            a = a - 16;
            tick(3'd3, a, r, w);
        end
        tick(fin, 0, rfin, w);
    endtask

    task automatic holdoff_rest(input int r, input logic w);
        for (int i = 0; i < 7; i++) tick(3'd4, 0, r, w);
    endtask

    // Monitor: one queued snapshot per cycle, compared mid-cycle
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            exp_t g;
            e = sbq.pop_front();
            g = e;
            g.st    = state;
            g.amp   = amp_scale;
            g.retry = retry_count;
            g.wen   = wd_enable;
            g.frc   = wd_force_reset;
            g.rf    = rf_enable;
            g.lock  = fault_lockout;
            g.warn  = warn_seen;
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL phase%0d snapshot: got st=%0d amp=%0d retry=%0d wen=%b frc=%b rf=%b lock=%b warn=%b, want st=%0d amp=%0d retry=%0d wen=%b frc=%b rf=%b lock=%b warn=%b",
                         e.phase, g.st, g.amp, g.retry, g.wen, g.frc, g.rf, g.lock, g.warn,
                         e.st, e.amp, e.retry, e.wen, e.frc, e.rf, e.lock, e.warn);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; tx_request = 1'b0; clear_fault = 1'b0;
        wd_triggered = 1'b0; wd_warning = 1'b0;

        // 1: reset, normal start, warning in RUN
        phase = 1;
        tick(3'd0, 0, 0, 1'b0);
        tick(3'd0, 0, 0, 1'b0);
        rst = 1'b0; tx_request = 1'b1;
        tick(3'd1, 0, 0, 1'b0);
        ramp_up_full(0);
        wd_warning = 1'b1;
        tick(3'd2, 255, 0, 1'b1);
        wd_warning = 1'b0;
        tick(3'd2, 255, 0, 1'b1);

        // 2: clean stop, warning stays sticky
        phase = 2;
        tx_request = 1'b0;
        tick(3'd3, 255, 0, 1'b1);
        ramp_down(255, 0, 1'b1, 3'd0, 0);
        clear_fault = 1'b1;
        tick(3'd0, 0, 0, 1'b1);
        clear_fault = 1'b0;

        // 3: fault recovery, restart through HOLDOFF
        phase = 3;
        tx_request = 1'b1;
        tick(3'd1, 0, 0, 1'b0);
        ramp_up_full(0);
        wd_triggered = 1'b1;
        tick(3'd3, 255, 1, 1'b0);
        wd_triggered = 1'b0;
        ramp_down(255, 1, 1'b0, 3'd4, 1);
        holdoff_rest(1, 1'b0);
        tick(3'd1, 0, 1, 1'b0);

        // 4: second and third faults reach LOCKOUT, then clear
        phase = 4;
        ramp_up_full(1);
        wd_triggered = 1'b1;
        tick(3'd3, 255, 2, 1'b0);
        wd_triggered = 1'b0;
        ramp_down(255, 2, 1'b0, 3'd4, 2);
        holdoff_rest(2, 1'b0);
        tick(3'd1, 0, 2, 1'b0);
        ramp_up_full(2);
        wd_triggered = 1'b1;
        tick(3'd3, 255, 3, 1'b0);
        wd_triggered = 1'b0;
        ramp_down(255, 3, 1'b0, 3'd5, 3);
        for (int i = 0; i < 3; i++) tick(3'd5, 0, 3, 1'b0);
        clear_fault = 1'b1;
        tick(3'd0, 0, 0, 1'b0);
        clear_fault = 1'b0;

        // 5: fault and stop in the same cycle, then aborted ramp-up at 96
        phase = 5;
        tick(3'd1, 0, 0, 1'b0);
        ramp_up_full(0);
        wd_triggered = 1'b1; tx_request = 1'b0;
        tick(3'd3, 255, 1, 1'b0);
        wd_triggered = 1'b0;
        ramp_down(255, 1, 1'b0, 3'd4, 1);
        holdoff_rest(1, 1'b0);
        tick(3'd0, 0, 0, 1'b0);
        tx_request = 1'b1;
        tick(3'd1, 0, 0, 1'b0);
        for (int i = 1; i <= 6; i++) tick(3'd1, 16 * i, 0, 1'b0);
        tx_request = 1'b0;
        tick(3'd3, 96, 0, 1'b0);
        ramp_down(96, 0, 1'b0, 3'd0, 0);

        // 6: warning cleared on restart, ignored inputs, reset mid ramp-down
        phase = 6;
        tx_request = 1'b1;
        tick(3'd1, 0, 0, 1'b0);
        ramp_up_full(0);
        wd_warning = 1'b1;
        tick(3'd2, 255, 0, 1'b1);
        wd_warning = 1'b0; wd_triggered = 1'b1;
        tick(3'd3, 255, 1, 1'b1);
        ramp_down(255, 1, 1'b1, 3'd4, 1);
        clear_fault = 1'b1;
        holdoff_rest(1, 1'b1);
        wd_triggered = 1'b0; clear_fault = 1'b0; wd_warning = 1'b1;
        tick(3'd1, 0, 1, 1'b0);
        for (int i = 1; i <= 8; i++) tick(3'd1, 16 * i, 1, 1'b0);
        wd_warning = 1'b0; tx_request = 1'b0;
        tick(3'd3, 128, 1, 1'b0);
        rst = 1'b1;
        tick(3'd0, 0, 0, 1'b0);
        rst = 1'b0;
        tick(3'd0, 0, 0, 1'b0);

        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d queued, want 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
